// File: rtl/ps2_keys_pkg.sv
// Scancodes, word field positions and key slots
// shared by the PS/2 keyboard control decoder.
package ps2_keys_pkg;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LCTRL = 8'h14;
    localparam logic [7:0] SC_LALT  = 8'h11;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_5     = 8'h2E;

    localparam int unsigned KB_TOGGLE  = 10;
    localparam int unsigned KB_PRESSED = 9;
    localparam int unsigned KB_EXT     = 8;

    localparam int unsigned NKEYS = 8;

    typedef enum logic [2:0] {
        K_UP,
        K_DOWN,
        K_LEFT,
        K_RIGHT,
        K_GAS,
        K_TRICK,
        K_START,
        K_COIN
    } key_e;

    function automatic logic key_match(
        input logic [10:0] w,
        input logic        ext,
        input logic [7:0]  sc
    );
        return (w[KB_EXT] == ext) && (w[7:0] == sc);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_pulse_stretch.sv
// Fixed-length pulse generator; a trigger while
// running reloads the full length.
module pulse_stretch #(
    parameter int unsigned LEN = 2949120
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic out
);

    localparam int unsigned W = $clog2(LEN + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        if (trig) begin
            cnt_d = W'(LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
        out_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key event word to game controls: held keys,
// last-pressed-wins direction resolution, coin pulse.
import ps2_keys_pkg::*;

module ps2_key_decoder #(
    parameter int unsigned COIN_PULSE     = 2949120,
    parameter bit          SOCD_LAST_WINS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        gas,
    output logic        trick,
    output logic        start,
    output logic        coin,
    output logic        key_event
);

    logic [NKEYS-1:0] held_q, held_d;
    logic [NKEYS-1:0] hit;
    logic last_h_q, last_h_d;
    logic last_v_q, last_v_d;
    logic prev_toggle_q, armed_q;
    logic up_q, down_q, left_q, right_q;
    logic up_d, down_d, left_d, right_d;
    logic key_event_q, key_event_d;
    logic ev, pressed;
    logic edge_l, edge_r, edge_u, edge_d, edge_coin;

    // {lo, hi}: lo is Left/Up, hi is Right/Down
    function automatic logic [1:0] socd(
        input logic lo,
        input logic hi,
        input logic last_hi
    );
        if (SOCD_LAST_WINS) begin
            return {lo & (~hi | ~last_hi),
                    hi & (~lo | last_hi)};
        end
        return {lo & ~hi, hi & ~lo};
    endfunction

    always_comb begin
        hit = '0;
        hit[K_UP]    = key_match(ps2_key, 1'b1, SC_UP);
        hit[K_DOWN]  = key_match(ps2_key, 1'b1, SC_DOWN);
        hit[K_LEFT]  = key_match(ps2_key, 1'b1, SC_LEFT);
        hit[K_RIGHT] = key_match(ps2_key, 1'b1, SC_RIGHT);
        hit[K_GAS]   = key_match(ps2_key, 1'b0, SC_LCTRL);
        hit[K_TRICK] = key_match(ps2_key, 1'b0, SC_LALT);
        hit[K_START] = key_match(ps2_key, 1'b0, SC_1);
        hit[K_COIN]  = key_match(ps2_key, 1'b0, SC_5);

        ev      = armed_q & (ps2_key[KB_TOGGLE] != prev_toggle_q);
        pressed = ps2_key[KB_PRESSED];

        held_d = held_q;
        for (int i = 0; i < NKEYS; i++) begin
            if (ev && hit[i]) begin
                held_d[i] = pressed;
            end
        end

        // typematic repeats arrive with the flag already set
        edge_l    = ev & hit[K_LEFT]  & pressed & ~held_q[K_LEFT];
        edge_r    = ev & hit[K_RIGHT] & pressed & ~held_q[K_RIGHT];
        edge_u    = ev & hit[K_UP]    & pressed & ~held_q[K_UP];
        edge_d    = ev & hit[K_DOWN]  & pressed & ~held_q[K_DOWN];
        edge_coin = ev & hit[K_COIN]  & pressed & ~held_q[K_COIN];

        last_h_d = last_h_q;
        if (edge_l) last_h_d = 1'b0;
        if (edge_r) last_h_d = 1'b1;
        last_v_d = last_v_q;
        if (edge_u) last_v_d = 1'b0;
        if (edge_d) last_v_d = 1'b1;

        {left_d, right_d} = socd(held_d[K_LEFT],
                                 held_d[K_RIGHT], last_h_d);
        {up_d, down_d}    = socd(held_d[K_UP],
                                 held_d[K_DOWN], last_v_d);

        key_event_d = ev & (|hit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q        <= '0;
            last_h_q      <= 1'b0;
            last_v_q      <= 1'b0;
            prev_toggle_q <= 1'b0;
            armed_q       <= 1'b0;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            key_event_q   <= 1'b0;
        end else begin
            held_q        <= held_d;
            last_h_q      <= last_h_d;
            last_v_q      <= last_v_d;
            prev_toggle_q <= ps2_key[KB_TOGGLE];
            armed_q       <= 1'b1;
            up_q          <= up_d;
            down_q        <= down_d;
            left_q        <= left_d;
            right_q       <= right_d;
            key_event_q   <= key_event_d;
        end
    end

    pulse_stretch #(
        .LEN(COIN_PULSE)
    ) u_coin (
        .clk  (clk),
        .reset(reset),
        .trig (edge_coin),
        .out  (coin)
    );

    assign up        = up_q;
    assign down      = down_q;
    assign left      = left_q;
    assign right     = right_q;
    assign gas       = held_q[K_GAS];
    assign trick     = held_q[K_TRICK];
    assign start     = held_q[K_START];
    assign key_event = key_event_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed plus random checks of the PS/2 control decoder
// in both direction-resolution modes against a key model.
module tb_ps2_key_decoder;

    localparam int LEN = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'h400;

    logic a_up, a_down, a_left, a_right;
    logic a_gas, a_trick, a_start, a_coin, a_kev;
    logic b_up, b_down, b_left, b_right;
    logic b_gas, b_trick, b_start, b_coin, b_kev;

    int n_cmp = 0;
    int n_bad = 0;

    bit held [8];
    bit m_last_h, m_last_v, m_prev, m_armed;
    int m_cnt;
    bit m_kev;

    bit          tog = 1'b1;
    logic [10:0] last_w = 11'h400;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .COIN_PULSE(LEN),
        .SOCD_LAST_WINS(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .up(a_up), .down(a_down), .left(a_left),
        .right(a_right), .gas(a_gas), .trick(a_trick),
        .start(a_start), .coin(a_coin), .key_event(a_kev)
    );

    ps2_key_decoder #(
        .COIN_PULSE(LEN),
        .SOCD_LAST_WINS(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .up(b_up), .down(b_down), .left(b_left),
        .right(b_right), .gas(b_gas), .trick(b_trick),
        .start(b_start), .coin(b_coin), .key_event(b_kev)
    );

    // slots: 0 up, 1 down, 2 left, 3 right,
    //        4 gas, 5 trick, 6 start, 7 coin
    function automatic int key_idx(input bit ext,
                                   input bit [7:0] sc);
        case ({ext, sc})
            9'h175:  return 0;
            9'h172:  return 1;
            9'h16B:  return 2;
            9'h174:  return 3;
            9'h014:  return 4;
            9'h011:  return 5;
            9'h016:  return 6;
            9'h02E:  return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        foreach (held[i]) held[i] = 1'b0;
        m_last_h = 1'b0;
        m_last_v = 1'b0;
        m_prev   = 1'b0;
        m_armed  = 1'b0;
        m_cnt    = 0;
        m_kev    = 1'b0;
    endtask

    task automatic model_edge(input logic [10:0] w);
        bit ev;
        bit loaded;
        int k;
        ev      = m_armed && (w[10] != m_prev);
        m_prev  = w[10];
        m_armed = 1'b1;
        k       = key_idx(w[8], w[7:0]);
        m_kev   = ev && (k >= 0);
        loaded  = 1'b0;
        if (m_kev) begin
            if (w[9] && !held[k]) begin
                if (k == 0) m_last_v = 1'b0;
                if (k == 1) m_last_v = 1'b1;
                if (k == 2) m_last_h = 1'b0;
                if (k == 3) m_last_h = 1'b1;
                if (k == 7) begin
                    m_cnt  = LEN;
                    loaded = 1'b1;
                end
            end
            held[k] = w[9];
        end
        if (!loaded && m_cnt > 0) m_cnt--;
    endtask

    function automatic logic [8:0] exp_vec(input bit lw);
        bit u, d, l, r;
        if (lw) begin
            l = held[2] && (!held[3] || !m_last_h);
            r = held[3] && (!held[2] || m_last_h);
            u = held[0] && (!held[1] || !m_last_v);
            d = held[1] && (!held[0] || m_last_v);
        end else begin
            l = held[2] && !held[3];
            r = held[3] && !held[2];
            u = held[0] && !held[1];
            d = held[1] && !held[0];
        end
        return {u, d, l, r, held[4], held[5], held[6],
                m_cnt != 0, m_kev};
    endfunction

    task automatic chk(input string tag,
                       input logic [8:0] obs,
                       input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] obs_a();
        return {a_up, a_down, a_left, a_right, a_gas,
                a_trick, a_start, a_coin, a_kev};
    endfunction

    function automatic logic [8:0] obs_b();
        return {b_up, b_down, b_left, b_right, b_gas,
                b_trick, b_start, b_coin, b_kev};
    endfunction

    task automatic step(input logic [10:0] w);
        ps2_key = w;
        last_w  = w;
        @(posedge clk);
        model_edge(w);
        #1;
        chk("outs_lastwins", obs_a(), exp_vec(1'b1));
        chk("outs_neutral", obs_b(), exp_vec(1'b0));
        @(negedge clk);
    endtask

    task automatic key(input bit ext, input bit p,
                       input bit [7:0] sc);
        tog = ~tog;
        step({tog, p, ext, sc});
    endtask

    task automatic idle(input int n);
        repeat (n) step(last_w);
    endtask

    // asserted mid low phase; outputs must drop before any edge
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_a", obs_a(), 9'd0);
        chk("async_rst_b", obs_b(), 9'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] codes [8];
        bit         exts  [8];
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74,
                  8'h14, 8'h11, 8'h16, 8'h2E};
        exts  = '{1, 1, 1, 1, 0, 0, 0, 0};
        model_reset();

        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            step(11'h400);
            chk("arm_no_event", {8'd0, a_kev}, 9'd0);
        end

        key(0, 1, 8'h14);
        chk("gas_press", {7'd0, a_gas, a_kev}, 9'd3);
        idle(1);
        chk("kev_one_cycle", {8'd0, a_kev}, 9'd0);
        key(0, 0, 8'h14);
        chk("gas_release", {8'd0, a_gas}, 9'd0);

        key(1, 1, 8'h6B);
        chk("left_only", {7'd0, a_left, a_right}, 9'd2);
        key(1, 1, 8'h74);
        chk("right_wins", {7'd0, a_left, a_right}, 9'd1);
        chk("both_neutral", {7'd0, b_left, b_right}, 9'd0);
        key(1, 0, 8'h74);
        chk("left_back", {7'd0, a_left, a_right}, 9'd2);
        key(1, 0, 8'h6B);

        key(0, 1, 8'h2E);
        idle(2);
        key(0, 0, 8'h2E);
        idle(6);
        chk("coin_last_cycle", {8'd0, a_coin}, 9'd1);
        idle(1);
        chk("coin_ended", {8'd0, a_coin}, 9'd0);

        key(0, 1, 8'h2E);
        repeat (3) key(0, 1, 8'h2E);
        idle(6);
        chk("coin_rpt_high", {8'd0, a_coin}, 9'd1);
        idle(1);
        chk("coin_no_extend", {8'd0, a_coin}, 9'd0);
        key(0, 0, 8'h2E);

        key(0, 1, 8'h2E);
        key(0, 0, 8'h2E);
        idle(3);
        key(0, 1, 8'h2E);
        idle(9);
        chk("coin_reload_hi", {8'd0, a_coin}, 9'd1);
        idle(1);
        chk("coin_reload_end", {8'd0, a_coin}, 9'd0);
        key(0, 0, 8'h2E);

        key(0, 1, 8'h6B);
        chk("nonext_6b", {8'd0, a_kev}, 9'd0);
        key(1, 1, 8'h14);
        chk("ext_14", {7'd0, a_gas, a_kev}, 9'd0);

        key(0, 1, 8'h14);
        key(0, 1, 8'h2E);
        idle(2);
        apply_reset();
        tog   = ~tog;
        reset = 1'b0;
        step({tog, 1'b1, 1'b0, 8'h14});
        chk("arm_ignores", {8'd0, a_gas}, 9'd0);
        key(0, 1, 8'h14);
        chk("gas_after_arm", {8'd0, a_gas}, 9'd1);

        for (int n = 0; n < 400; n++) begin
            int         k;
            bit         e;
            logic [7:0] sc;
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
                reset = 1'b0;
            end
            k = $urandom_range(0, 8);
            if (k < 8) begin
                sc = codes[k];
                e  = exts[k];
                if ($urandom_range(0, 9) == 0) e = ~e;
            end else begin
                sc = 8'($urandom);
                e  = 1'($urandom);
            end
            if ($urandom_range(0, 3) != 0) tog = ~tog;
            step({tog, 1'($urandom), e, sc});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
